// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache with zero-cycle hit and a burst line fill over a valid-beat handshake.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_direct_mapped #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr_f,
  output logic        icache_stall,
  input  logic        icache_inv,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int OFF   = $clog2(LINE_WORDS);
  localparam int IDX   = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - OFF - IDX;

  typedef enum logic {IDLE, FILL} state_t;

  state_t           state;
  logic [OFF-1:0]   beat;
  logic [IDX-1:0]   fill_idx;
  logic [TAG_W-1:0] fill_tag;

  logic [31:0]      data_q [NUM_LINES][LINE_WORDS];
  logic [TAG_W-1:0] tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;

  logic [OFF-1:0]   pc_word;
  logic [IDX-1:0]   pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic             hit, beat_we, last_beat;
  logic             unused_pc_bits;

  assign pc_word        = pc[OFF+1:2];
  assign pc_idx         = pc[OFF+IDX+1:OFF+2];
  assign pc_tag         = pc[31:OFF+IDX+2];
  assign unused_pc_bits = ^pc[1:0];

  assign hit          = (state == IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign icache_stall = ~hit;
  assign instr_f      = hit ? data_q[pc_idx][pc_word] : 32'h0;

  // A beat is only taken while filling and never on a reset cycle.
  assign beat_we   = (state == FILL) && mem_valid && !reset;
  assign last_beat = beat_we && (beat == OFF'(LINE_WORDS - 1));

  assign mem_req  = (state == FILL);
  assign mem_addr = (state == FILL) ? {fill_tag, fill_idx, beat, 2'b00} : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      beat     <= '0;
      fill_idx <= '0;
      fill_tag <= '0;
      valid_q  <= '0;
    end else begin
      case (state)
        IDLE: if (!hit) begin
          state    <= FILL;
          fill_idx <= pc_idx;
          fill_tag <= pc_tag;
          beat     <= '0;
        end
        FILL: if (beat_we) begin
          beat <= beat + 1'b1;
          if (last_beat) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Invalidate wins over the line-complete set, leaving a just-filled line invalid.
      if (icache_inv)     valid_q           <= '0;
      else if (last_beat) valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_we)   data_q[fill_idx][beat] <= mem_rdata;
    if (last_beat) tag_q[fill_idx]        <= fill_tag;
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped; backing memory returns {16'hC0DE, addr[15:0]} on valid beats
// and a poison word otherwise, so any non-beat sample shows up as wrong instruction data.
module tb_icache_direct_mapped;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr_f;
  logic        icache_stall;
  logic        icache_inv;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int tests = 0;
  int fails = 0;
  int mode  = 0;   // 0: no beats, 1: beat every cycle, 3: beat every 3rd cycle
  int ws_cnt = 0;
  int n;

  icache_direct_mapped dut (
    .clk(clk), .reset(reset), .pc(pc), .instr_f(instr_f), .icache_stall(icache_stall),
    .icache_inv(icache_inv), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  always_comb mem_rdata = mem_valid ? {16'hC0DE, mem_addr[15:0]} : 32'hBAD0_BAD0;

  always @(negedge clk) begin
    if (mode == 3) begin
      mem_valid = (ws_cnt == 2);
      ws_cnt    = (ws_cnt == 2) ? 0 : ws_cnt + 1;
    end else begin
      ws_cnt    = 0;
      mem_valid = (mode == 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts stall cycles from the current one until a hit, bounded.
  task automatic run_fill(output int cnt);
    cnt = 0;
    while (icache_stall && cnt < 100) begin
      cnt++;
      tick();
    end
    if (cnt >= 100) chk("fill_timeout", 32'(cnt), 32'd0);
  endtask

  initial begin
    reset = 1'b1; pc = 32'h0040_0000; icache_inv = 1'b0; mode = 0;
    tick(); tick();
    chk("rst_req",   {31'b0, mem_req}, 32'd0);
    chk("rst_addr",  mem_addr, 32'h0);
    chk("rst_stall", {31'b0, icache_stall}, 32'd1);
    chk("rst_instr", instr_f, 32'h0);
`ifdef ICACHE_STATS_EN
    chk("rst_miss_cnt", miss_count, 32'd0);
`endif

    // Cold miss, zero-wait memory
    reset = 1'b0; mode = 1;
    tick();
    chk("cold_req0",   {31'b0, mem_req}, 32'd1);
    chk("cold_addr0",  mem_addr, 32'h0040_0000);
    chk("cold_stall0", {31'b0, icache_stall}, 32'd1);
    tick(); chk("cold_addr1", mem_addr, 32'h0040_0004);
    tick(); chk("cold_addr2", mem_addr, 32'h0040_0008);
    tick(); chk("cold_addr3", mem_addr, 32'h0040_000C);
    chk("cold_stall3", {31'b0, icache_stall}, 32'd1);
    tick();
    chk("cold_hit",   {31'b0, icache_stall}, 32'd0);
    chk("cold_instr", instr_f, 32'hC0DE_0000);
    chk("cold_noreq", {31'b0, mem_req}, 32'd0);

    // Same-line hits
    mode = 0;
    pc = 32'h0040_0004; #1;
    chk("hit4_stall", {31'b0, icache_stall}, 32'd0);
    chk("hit4_instr", instr_f, 32'hC0DE_0004);
    pc = 32'h0040_0008; #1;
    chk("hit8_instr", instr_f, 32'hC0DE_0008);
    pc = 32'h0040_000C; #1;
    chk("hitC_instr", instr_f, 32'hC0DE_000C);
    tick();
    chk("hitC_noreq", {31'b0, mem_req}, 32'd0);
    chk("hitC_hold",  instr_f, 32'hC0DE_000C);

    // Conflict eviction on index 0
    mode = 1;
    pc = 32'h0040_0100; #1;
    chk("conf1_miss", {31'b0, icache_stall}, 32'd1);
    run_fill(n);
    chk("conf1_stalls", 32'(n), 32'd5);
    chk("conf1_instr", instr_f, 32'hC0DE_0100);
    pc = 32'h0040_0000; #1;
    chk("conf2_miss", {31'b0, icache_stall}, 32'd1);
    run_fill(n);
    chk("conf2_stalls", 32'(n), 32'd5);
    chk("conf2_instr", instr_f, 32'hC0DE_0000);
`ifdef ICACHE_STATS_EN
    chk("conf_miss_cnt", miss_count, 32'd3);
`endif

    // Wait-state fill from a non-zero word
    pc = 32'h0040_0018; mode = 3; #1;
    chk("ws_miss", {31'b0, icache_stall}, 32'd1);
    tick(); chk("ws_addr_b0",   mem_addr, 32'h0040_0010);
    tick(); chk("ws_addr_hold", mem_addr, 32'h0040_0010);
    tick(); chk("ws_addr_b1",   mem_addr, 32'h0040_0014);
    run_fill(n);
    chk("ws_stalls_rest", 32'(n), 32'd9);
    chk("ws_instr", instr_f, 32'hC0DE_0018);
    pc = 32'h0040_0010; #1;
    chk("ws_instr_w0", instr_f, 32'hC0DE_0010);
    pc = 32'h0040_001C; #1;
    chk("ws_instr_w3", instr_f, 32'hC0DE_001C);

    // Invalidate on the last beat
    pc = 32'h0040_0020; mode = 1; #1;
    tick(); tick(); tick(); tick();
    chk("inv_lastaddr", mem_addr, 32'h0040_002C);
    icache_inv = 1'b1;
    tick();
    icache_inv = 1'b0;
    chk("inv_remiss", {31'b0, icache_stall}, 32'd1);
    chk("inv_idle",   {31'b0, mem_req}, 32'd0);
    tick();
    chk("inv_req2",  {31'b0, mem_req}, 32'd1);
    chk("inv_addr2", mem_addr, 32'h0040_0020);
    run_fill(n);
    chk("inv_stalls2", 32'(n), 32'd4);
    chk("inv_instr", instr_f, 32'hC0DE_0020);
    pc = 32'h0040_0000; #1;
    chk("inv_all_cleared", {31'b0, icache_stall}, 32'd1);

    // Reset mid-fill after beat 1
    pc = 32'h0040_0030; #1;
    tick();
    tick();
    chk("rmid_addr_b1", mem_addr, 32'h0040_0034);
    reset = 1'b1;
    tick();
    chk("rmid_req",  {31'b0, mem_req}, 32'd0);
    chk("rmid_addr", mem_addr, 32'h0);
    pc = 32'h0040_000C; #1;
    chk("rmid_valid_clr", {31'b0, icache_stall}, 32'd1);
    chk("rmid_instr", instr_f, 32'h0);
`ifdef ICACHE_STATS_EN
    chk("rmid_miss_cnt", miss_count, 32'd0);
`endif
    pc = 32'h0040_0030; reset = 1'b0;
    tick();
    chk("rmid_refill_addr", mem_addr, 32'h0040_0030);
    run_fill(n);
    chk("rmid_stalls", 32'(n), 32'd4);
    chk("rmid_instr", instr_f, 32'hC0DE_0030);
    pc = 32'h0040_0034; #1;
    chk("rmid_instr_w1", instr_f, 32'hC0DE_0034);

    mode = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
